qeciphy_pchannel_initiator: RTL

QECIPHY_PCHANNEL_INITIATOR -- requirements
Module: qeciphy_pchannel_initiator

---
 rtl/qeciphy_pkg.sv | 16 +
 rtl/qeciphy_pchannel_initiator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/qeciphy_pkg.sv
// Shared types and constants for the QECi PHY P-channel initiator.
package qeciphy_pkg;

  localparam logic PSTATE_OFF = 1'b0;
  localparam logic PSTATE_ON  = 1'b1;

  localparam int unsigned TCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_ACK   = 2'd3
  } pch_state_e;

endpackage

// File: rtl/qeciphy_pchannel_initiator.sv
// P-channel initiator: drives the PHY PSTATE/PREQ handshake on user or PACTIVE wake requests.
// Optional handshake timeout flag is enabled by defining QECIPHY_PCH_TIMEOUT_EN.
module qeciphy_pchannel_initiator
  import qeciphy_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic        RESET_PSTATE   = 1'b0
) (
  input  logic axis_clk,
  input  logic axis_rst,
  input  logic i_req_valid,
  input  logic i_req_state,
  output logic o_req_ready,
  input  logic i_auto_wake_en,
  output logic o_pstate,
  output logic o_preq,
  input  logic i_paccept,
  input  logic i_pactive,
  output logic o_cur_state,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout,
  input  logic i_timeout_clr
);

  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

  pch_state_e state, state_n;
  logic       pstate_n;
  logic       preq_n;
  logic       cur_state_n;
  logic       done_n;

  // State and registered handshake outputs
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state       <= ST_IDLE;
      o_pstate    <= RESET_PSTATE;
      o_preq      <= 1'b0;
      o_cur_state <= RESET_PSTATE;
      o_done      <= 1'b0;
    end else begin
      state       <= state_n;
      o_pstate    <= pstate_n;
      o_preq      <= preq_n;
      o_cur_state <= cur_state_n;
      o_done      <= done_n;
    end
  end

  // Next-state logic; user request takes priority over PACTIVE wake
  always_comb begin
    state_n     = state;
    pstate_n    = o_pstate;
    preq_n      = o_preq;
    cur_state_n = o_cur_state;
    done_n      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (i_req_state != o_cur_state) begin
            pstate_n = i_req_state;
            state_n  = ST_SETUP;
          end else begin
            done_n = 1'b1;
          end
        end else if (i_auto_wake_en && (o_cur_state == PSTATE_OFF) && i_pactive) begin
          pstate_n = PSTATE_ON;
          state_n  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        preq_n  = 1'b1;
        state_n = ST_REQ;
      end
      ST_REQ: begin
        if (i_paccept) begin
          preq_n      = 1'b0;
          cur_state_n = o_pstate;
          state_n     = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!i_paccept) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_req_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);

`ifdef QECIPHY_PCH_TIMEOUT_EN
  logic [TCNT_W-1:0] tcnt;
  logic              in_hs;
  logic              hs_enter;

  assign in_hs    = (state == ST_REQ) || (state == ST_ACK);
  assign hs_enter = ((state_n == ST_REQ) && (state != ST_REQ)) ||
                    ((state_n == ST_ACK) && (state != ST_ACK));

  // Phase-cycle counter and sticky flag; a set wins over a same-cycle clear
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      tcnt      <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (hs_enter) begin
        tcnt <= '0;
      end else if (in_hs) begin
        tcnt <= tcnt + TCNT_W'(1);
      end
      if (in_hs && (tcnt == TCNT_MAX)) begin
        o_timeout <= 1'b1;
      end else if (i_timeout_clr) begin
        o_timeout <= 1'b0;
      end
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{i_timeout_clr, TCNT_MAX};
  assign o_timeout  = 1'b0;
`endif

endmodule
